directory_client_arbiter: RTL and testbench

DIRECTORY_CLIENT_ARBITER -- requirements
Module: directory_client_arbiter

---
 rtl/directory_client_arbiter_pkg.sv | 36 +++
 rtl/rr_pick4.sv | 25 ++
 rtl/directory_client_arbiter.sv | 134 +++++++++++++
 tb/tb_directory_client_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/directory_client_arbiter_pkg.sv
// rtl/directory_client_arbiter_pkg.sv - shared directory sizes, client encoding and request layout
package directory_client_arbiter_pkg;

    localparam int INDEX_WIDTH  = 12;
    localparam int ROW_SIZE     = 20;
    localparam int ENTRY_SIZE   = 4 * ROW_SIZE;
    localparam int NUM_CLIENTS  = 4;
    localparam int CLIENT_WIDTH = 2;

    // dir_put_request = {idx, write, row, core_id, cache_type}, offsets from bit 0
    localparam int PUT_WIDTH          = INDEX_WIDTH + 1 + ROW_SIZE + CLIENT_WIDTH;
    localparam int PUT_CACHE_TYPE_LSB = 0;
    localparam int PUT_CORE_ID_LSB    = 1;
    localparam int PUT_ROW_LSB        = 2;
    localparam int PUT_WRITE_LSB      = PUT_ROW_LSB + ROW_SIZE;
    localparam int PUT_IDX_LSB        = PUT_WRITE_LSB + 1;

    typedef enum logic [1:0] {
        CLIENT_IMEM0 = 2'd0,
        CLIENT_DMEM0 = 2'd1,
        CLIENT_IMEM1 = 2'd2,
        CLIENT_DMEM1 = 2'd3
    } client_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_GET = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

    function automatic logic [1:0] next_client(input logic [1:0] c);
        return c + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - picks the first valid of four at or after ptr, wrapping 3->0
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] cand;

    // Walk the offsets from far to near so the nearest valid one wins.
    always_comb begin
        grant = ptr;
        cand  = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (valid[cand]) begin
                grant = cand;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/directory_client_arbiter.sv
// rtl/directory_client_arbiter.sv - four-client round-robin front end to a single directory port
module directory_client_arbiter #(
    parameter int INDEX_WIDTH = directory_client_arbiter_pkg::INDEX_WIDTH,
    parameter int ROW_SIZE    = directory_client_arbiter_pkg::ROW_SIZE,
    parameter int ENTRY_SIZE  = directory_client_arbiter_pkg::ENTRY_SIZE
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [3:0]                      req_valid,
    output logic [3:0]                      req_ready,
    input  logic [4*INDEX_WIDTH-1:0]        req_idx,
    input  logic [3:0]                      req_write,
    input  logic [4*ROW_SIZE-1:0]           req_row,
    output logic [3:0]                      resp_valid,
    input  logic [3:0]                      resp_ready,
    output logic [ENTRY_SIZE-1:0]           resp_data,
    output logic                            dir_put_valid,
    input  logic                            dir_put_ready,
    output logic [INDEX_WIDTH+ROW_SIZE+2:0] dir_put_request,
    output logic                            dir_get_valid,
    input  logic                            dir_get_ready,
    input  logic [ENTRY_SIZE-1:0]           dir_get_response
);
    import directory_client_arbiter_pkg::*;

    logic [3:0]             buf_valid;
    logic [3:0]             buf_write;
    logic [INDEX_WIDTH-1:0] buf_idx [4];
    logic [ROW_SIZE-1:0]    buf_row [4];

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] buf_clear;
    logic       resp_load;
    logic [1:0] pick;
    logic       pick_any;

    rr_pick4 u_pick (
        .valid (buf_valid),
        .ptr   (rr_ptr_q),
        .grant (pick),
        .any   (pick_any)
    );

    // Gated by RST_N so no client sees an accept while the block is held in reset.
    assign req_ready = ~buf_valid & {4{RST_N}};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_valid <= '0;
            buf_write <= '0;
            for (int p = 0; p < 4; p++) begin
                buf_idx[p] <= '0;
                buf_row[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (req_valid[p] && !buf_valid[p]) begin
                    buf_valid[p] <= 1'b1;
                    buf_write[p] <= req_write[p];
                    buf_idx[p]   <= req_idx[p*INDEX_WIDTH +: INDEX_WIDTH];
                    buf_row[p]   <= req_row[p*ROW_SIZE +: ROW_SIZE];
                end else if (buf_clear[p]) begin
                    buf_valid[p] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        buf_clear = '0;
        resp_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dir_put_ready) begin
                    if (buf_write[grant_q]) begin
                        buf_clear[grant_q] = 1'b1;
                        rr_ptr_d           = next_client(grant_q);
                        state_d            = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_GET;
                    end
                end
            end
            ST_WAIT_GET: begin
                if (dir_get_ready) begin
                    resp_load = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[grant_q]) begin
                    buf_clear[grant_q] = 1'b1;
                    rr_ptr_d           = next_client(grant_q);
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'd0;
            rr_ptr_q  <= 2'd0;
            resp_data <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (resp_load) begin
                resp_data <= dir_get_response;
            end
        end
    end

    // Client number doubles as {core_id, cache_type}.
    assign dir_put_valid   = (state_q == ST_ISSUE);
    assign dir_get_valid   = (state_q == ST_WAIT_GET);
    assign resp_valid      = (state_q == ST_RESP) ? (4'b0001 << grant_q) : 4'b0000;
    assign dir_put_request = {buf_idx[grant_q], buf_write[grant_q], buf_row[grant_q], grant_q};

endmodule

// File: tb/tb_directory_client_arbiter.sv
// tb/tb_directory_client_arbiter.sv - scoreboard bench for directory_client_arbiter
module tb_directory_client_arbiter;

    localparam int IW = 12;
    localparam int RW = 20;
    localparam int EW = 80;
    localparam int PW = IW + 1 + RW + 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [4*IW-1:0] req_idx = '0;
    logic [3:0]    req_write = '0;
    logic [4*RW-1:0] req_row = '0;
    logic [3:0]    resp_valid;
    logic [3:0]    resp_ready = '0;
    logic [EW-1:0] resp_data;
    logic          dir_put_valid;
    logic          dir_put_ready = 1'b0;
    logic [PW-1:0] dir_put_request;
    logic          dir_get_valid;
    logic          dir_get_ready = 1'b0;
    logic [EW-1:0] dir_get_response = '0;

    always #5 CLK = ~CLK;

    directory_client_arbiter #(
        .INDEX_WIDTH (IW),
        .ROW_SIZE    (RW),
        .ENTRY_SIZE  (EW)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_idx          (req_idx),
        .req_write        (req_write),
        .req_row          (req_row),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .dir_put_valid    (dir_put_valid),
        .dir_put_ready    (dir_put_ready),
        .dir_put_request  (dir_put_request),
        .dir_get_valid    (dir_get_valid),
        .dir_get_ready    (dir_get_ready),
        .dir_get_response (dir_get_response)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    logic [PW-1:0]   put_q [$];
    logic [EW+3:0]   resp_q [$];
    int              put_stall = 0;
    int              get_delay = 0;
    int              resp_delay = 0;
    int              put_wait = 0;
    int              get_wait = 0;
    int              resp_wait = 0;
    logic [PW-1:0]   hold_req = '0;
    logic [IW-1:0]   last_idx = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] dir_entry(input logic [IW-1:0] idx);
        return {4{{idx, ~idx[7:0]}}};
    endfunction

    task automatic load(input int p, input logic w, input logic [IW-1:0] idx, input logic [RW-1:0] row);
        logic [3:0] m;
        m = 4'b0001 << p;
        req_valid[p] = 1'b1;
        req_write[p] = w;
        req_idx[p*IW +: IW] = idx;
        req_row[p*RW +: RW] = row;
        put_q.push_back({idx, w, row, 2'(p)});
        if (!w) resp_q.push_back({m, dir_entry(idx)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 300 && !(put_q.size() == 0 && resp_q.size() == 0 && !dir_put_valid &&
                            !dir_get_valid && resp_valid == 4'b0 && req_ready == 4'hF)) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 128'(n < 300), 128'(1));
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check_eq({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        check_eq({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
        check_eq({tag, "_put_valid"}, 128'(dir_put_valid), 128'(0));
        check_eq({tag, "_get_valid"}, 128'(dir_get_valid), 128'(0));
        check_eq({tag, "_resp_data"}, 128'(resp_data), 128'(0));
        check_eq({tag, "_put_req"}, 128'(dir_put_request), 128'(0));
        put_q.delete();
        resp_q.delete();
        req_valid = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Directory and response-consumer model; decisions made here take effect at the next rising edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            dir_put_ready = 1'b0;
            dir_get_ready = 1'b0;
            resp_ready    = '0;
            put_wait      = 0;
            get_wait      = 0;
            resp_wait     = 0;
        end else begin
            if (dir_put_valid || dir_get_valid)
                check_eq("one_outstanding", 128'(dir_put_valid & dir_get_valid), 128'(0));

            if (dir_put_valid) begin
                if (put_wait < put_stall) begin
                    if (put_wait == 0) hold_req = dir_put_request;
                    else check_eq("put_hold", 128'(dir_put_request), 128'(hold_req));
                    check_eq("stall_req_ready", 128'(req_ready[dir_put_request[1:0]]), 128'(0));
                    dir_put_ready = 1'b0;
                    put_wait++;
                end else begin
                    dir_put_ready = 1'b1;
                    put_wait = 0;
                    if (put_q.size() == 0) check_eq("put_unexpected", 128'(put_q.size()), 128'(1));
                    else check_eq("put_request", 128'(dir_put_request), 128'(put_q.pop_front()));
                    last_idx = dir_put_request[PW-1 -: IW];
                end
            end else begin
                dir_put_ready = 1'b0;
                put_wait = 0;
            end

            if (dir_get_valid) begin
                if (get_wait < get_delay) begin
                    dir_get_ready    = 1'b0;
                    dir_get_response = ~dir_entry(last_idx);
                    get_wait++;
                end else begin
                    dir_get_ready    = 1'b1;
                    dir_get_response = dir_entry(last_idx);
                    get_wait = 0;
                end
            end else begin
                dir_get_ready    = 1'b0;
                dir_get_response = ~dir_entry(last_idx);
                get_wait = 0;
            end

            if (resp_valid != 4'b0) begin
                check_eq("put_during_resp", 128'(dir_put_valid), 128'(0));
                if (resp_wait < resp_delay) begin
                    resp_ready = ~resp_valid;
                    resp_wait++;
                end else begin
                    resp_ready = resp_valid;
                    resp_wait = 0;
                    if (resp_q.size() == 0) check_eq("resp_unexpected", 128'(resp_q.size()), 128'(1));
                    else check_eq("resp", 128'({resp_valid, resp_data}), 128'(resp_q.pop_front()));
                end
            end else begin
                resp_ready = '0;
                resp_wait = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 RST_N = 1'b0;
        #2;
        check_eq("rst_req_ready", 128'(req_ready), 128'(0));
        check_eq("rst_resp_valid", 128'(resp_valid), 128'(0));
        check_eq("rst_put_valid", 128'(dir_put_valid), 128'(0));
        check_eq("rst_get_valid", 128'(dir_get_valid), 128'(0));
        check_eq("rst_resp_data", 128'(resp_data), 128'(0));
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // single write, client 1
        @(negedge CLK);
        check_eq("w_ready_before", 128'(req_ready[1]), 128'(1));
        load(1, 1'b1, 12'h0A5, 20'h81234);
        @(negedge CLK);
        req_valid = '0;
        check_eq("w_lat_e1", 128'(dir_put_valid), 128'(0));
        @(negedge CLK);
        check_eq("w_lat_e2", 128'(dir_put_valid), 128'(1));
        check_eq("w_busy_ready", 128'(req_ready[1]), 128'(0));
        drain("w_drain");

        // zero-wait read latency, client 3
        @(negedge CLK);
        load(3, 1'b0, 12'h123, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        check_eq("r_lat_e1", 128'(dir_put_valid), 128'(0));
        @(negedge CLK);
        check_eq("r_lat_e2", 128'(dir_put_valid), 128'(1));
        @(negedge CLK);
        check_eq("r_lat_e3", 128'(dir_get_valid), 128'(1));
        @(negedge CLK);
        check_eq("r_lat_e4", 128'(resp_valid), 128'(4'b1000));
        drain("r_drain");

        // late directory response, client 2, held response
        get_delay = 3;
        resp_delay = 3;
        @(negedge CLK);
        load(2, 1'b0, 12'hFFF, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        drain("late_drain");
        get_delay = 0;
        resp_delay = 0;

        // all four on one edge from rr_ptr 0, then client 0 refills
        pulse_reset("rr");
        @(negedge CLK);
        load(0, 1'b1, 12'h010, 20'hA0000);
        load(1, 1'b0, 12'h011, 20'h0);
        load(2, 1'b1, 12'h012, 20'hA2222);
        load(3, 1'b0, 12'h013, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_eq("rr_refill_wait", 128'(n < 50), 128'(1));
        load(0, 1'b0, 12'h020, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        drain("rr_drain");

        // directory put stalled for 10 cycles
        put_stall = 10;
        @(negedge CLK);
        load(2, 1'b1, 12'h2C2, 20'h55AA5);
        @(negedge CLK);
        req_valid = '0;
        drain("stall_drain");
        put_stall = 0;

        // reset in the middle of WAIT_GET
        get_delay = 20;
        @(negedge CLK);
        load(1, 1'b0, 12'h3C3, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        n = 0;
        while (!dir_get_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("mid_get_reached", 128'(n < 20), 128'(1));
        @(negedge CLK);
        pulse_reset("rst_mid");
        get_delay = 0;
        @(negedge CLK);
        check_eq("post_rst_put_valid", 128'(dir_put_valid), 128'(0));
        check_eq("post_rst_get_valid", 128'(dir_get_valid), 128'(0));
        check_eq("post_rst_ready", 128'(req_ready), 128'(4'hF));
        load(1, 1'b0, 12'h3C3, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        drain("post_rst_drain");

        // slow response consumer on client 3 with client 0 waiting behind it
        resp_delay = 5;
        @(negedge CLK);
        load(3, 1'b0, 12'h0F3, 20'h0);
        @(negedge CLK);
        req_valid = '0;
        load(0, 1'b1, 12'h0F0, 20'h0BEEF);
        @(negedge CLK);
        req_valid = '0;
        drain("slow_resp_drain");
        resp_delay = 0;

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
